// File: rtl/bram_arb_pkg.sv
// Shared constants, FSM encoding and small helpers for the BRAM port-B arbiter.
package bram_arb_pkg;

  localparam int N_REQ   = 3;
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;
  localparam int REQ_DBG = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'(REQ_CPU);
    if (oh[REQ_DMA]) idx = 2'(REQ_DMA);
    if (oh[REQ_DBG]) idx = 2'(REQ_DBG);
    return idx;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/bram_arb_select.sv
// Next-owner choice: round-robin from ptr with BRAM_ARB_FAIR_EN, fixed priority 0 > 1 > 2 otherwise.
module bram_arb_select
  import bram_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] choice
);

`ifdef BRAM_ARB_FAIR_EN
  always_comb begin
    choice = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = (int'(ptr) + i) % N_REQ;
      if (choice == '0 && req[k]) choice[k] = 1'b1;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    choice = '0;
    if (req[REQ_CPU])      choice[REQ_CPU] = 1'b1;
    else if (req[REQ_DMA]) choice[REQ_DMA] = 1'b1;
    else if (req[REQ_DBG]) choice[REQ_DBG] = 1'b1;
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Three-requester arbiter for BRAM port B with burst limiting; BRAM_ARB_FAIR_EN selects
// round-robin hand-over, otherwise fixed priority.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_req,
  input  logic [2:0]            i_we,
  input  logic [3*ADDR_W-1:0]   i_addr,
  input  logic [3*DATA_W-1:0]   i_wdata,
  output logic [2:0]            o_gnt,
  output logic [2:0]            o_rvalid,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_bram_we,
  output logic [ADDR_W-1:0]     o_bram_addr,
  output logic [DATA_W-1:0]     o_bram_di,
  input  logic [DATA_W-1:0]     i_bram_do,
  output arb_state_e            o_state
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_LEN);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] beat_q, beat_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] rvalid_q;

  logic [2:0] own_oh, others, cand, sel_oh, gnt_raw;
  logic       owner_req, at_limit, force_rearb;
  logic [1:0] gnt_idx;

  // Handshake: i_req[n] is a level request; the access (i_we/i_addr/i_wdata of n)
  // is accepted in the cycle o_gnt[n] is high, and reads return one cycle later.
  assign own_oh      = 3'b001 << owner_q;
  assign owner_req   = (state_q == ST_OWNED) && |(i_req & own_oh);
  assign at_limit    = beat_q >= BURST_LIM;
  assign others      = i_req & ~own_oh;
  assign force_rearb = owner_req && at_limit && |others;
  assign cand        = force_rearb ? others : i_req;

  bram_arb_select u_select (
    .req    (cand),
    .ptr    (ptr_q),
    .choice (sel_oh)
  );

`ifdef BRAM_ARB_FAIR_EN
  assign gnt_raw = (owner_req && !at_limit) ? own_oh : sel_oh;
`else
  assign gnt_raw = sel_oh;
`endif

  // Reset gates the grant so nothing reaches the BRAM while i_rst is low.
  assign o_gnt   = i_rst ? gnt_raw : 3'b000;
  assign gnt_idx = onehot_to_idx(o_gnt);

  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    beat_d  = 4'd0;
    ptr_d   = ptr_q;
    if (o_gnt != 3'b000) begin
      state_d = ST_OWNED;
      owner_d = gnt_idx;
      ptr_d   = next_idx(gnt_idx);
      beat_d  = (owner_req && gnt_idx == owner_q && !at_limit) ? beat_q + 4'd1 : 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 2'd0;
      beat_q   <= 4'd0;
      ptr_q    <= 2'd0;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      ptr_q    <= ptr_d;
      rvalid_q <= o_gnt & ~i_we;
    end
  end

  always_comb begin
    o_bram_we   = 1'b0;
    o_bram_addr = '0;
    o_bram_di   = '0;
    for (int n = 0; n < N_REQ; n++) begin
      if (o_gnt[n]) begin
        o_bram_we   = i_we[n];
        o_bram_addr = i_addr[n*ADDR_W +: ADDR_W];
        o_bram_di   = i_wdata[n*DATA_W +: DATA_W];
      end
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = (rvalid_q != 3'b000) ? i_bram_do : '0;
  assign o_state  = state_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: vector table plus burst, sole-requester and reset sequences.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  req, we;
  logic [15:0] a0, a1, a2;
  logic [7:0]  w2, bdo;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, bram_di;
  logic        bram_we;
  logic [15:0] bram_addr;
  arb_state_e  state;

  int n_checks = 0;
  int n_fail   = 0;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_LEN(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      ({a2, a1, a0}),
    .i_wdata     ({w2, 8'h00, 8'h00}),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_bram_we   (bram_we),
    .o_bram_addr (bram_addr),
    .o_bram_di   (bram_di),
    .i_bram_do   (bdo),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req, we;
    logic [15:0] a0, a1, a2;
    logic [7:0]  w2, bdo;
    logic [2:0]  gnt, rv;
    logic [7:0]  rd;
    logic        bwe;
    logic [15:0] baddr;
    logic [7:0]  bdi;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [15:0] x0,
                     input logic [15:0] x1, input logic [15:0] x2, input logic [7:0] d2,
                     input logic [7:0] bd, input logic [2:0] eg, input logic [2:0] erv,
                     input logic [7:0] erd, input logic ewe, input logic [15:0] ea,
                     input logic [7:0] edi);
    vec_t v;
    v.req = r; v.we = w; v.a0 = x0; v.a1 = x1; v.a2 = x2; v.w2 = d2; v.bdo = bd;
    v.gnt = eg; v.rv = erv; v.rd = erd; v.bwe = ewe; v.baddr = ea; v.bdi = edi;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [15:0] x0,
                       input logic [15:0] x1, input logic [15:0] x2, input logic [7:0] d2,
                       input logic [7:0] bd);
    req = r; we = w; a0 = x0; a1 = x1; a2 = x2; w2 = d2; bdo = bd;
  endtask

  logic [2:0] burst_exp[10];

  initial begin
    rst = 1'b0;
    drive(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
`ifdef BRAM_ARB_FAIR_EN
    burst_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001};
`else
    burst_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
`endif

    // Reset state
    #12;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_bram_we", 32'(bram_we), 32'h0);
    chk("reset_bram_addr", 32'(bram_addr), 32'h0);
    chk("reset_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    //   req     we      a0       a1       a2       w2     bdo    gnt     rv      rd     bwe   baddr    bdi
    add(3'b001, 3'b000, 16'h0200, 16'h0, 16'h0, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00, 1'b0, 16'h0200, 8'h00);
    add(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'h5A, 3'b000, 3'b001, 8'h5A, 1'b0, 16'h0000, 8'h00);
    add(3'b100, 3'b100, 16'h0, 16'h0, 16'h1234, 8'hC3, 8'h77, 3'b100, 3'b000, 8'h00, 1'b1, 16'h1234, 8'hC3);
    add(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'h77, 3'b000, 3'b000, 8'h00, 1'b0, 16'h0000, 8'h00);
    add(3'b110, 3'b000, 16'h0, 16'h0011, 16'h0022, 8'h00, 8'h00, 3'b010, 3'b000, 8'h00, 1'b0, 16'h0011, 8'h00);
    add(3'b100, 3'b000, 16'h0, 16'h0011, 16'h0022, 8'h00, 8'h11, 3'b100, 3'b010, 8'h11, 1'b0, 16'h0022, 8'h00);
    add(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'h22, 3'b000, 3'b100, 8'h22, 1'b0, 16'h0000, 8'h00);
    add(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'h33, 3'b000, 3'b000, 8'h00, 1'b0, 16'h0000, 8'h00);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].w2, vecs[i].bdo);
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_bram_we", i), 32'(bram_we), 32'(vecs[i].bwe));
      chk($sformatf("vec%0d_bram_addr", i), 32'(bram_addr), 32'(vecs[i].baddr));
      chk($sformatf("vec%0d_bram_di", i), 32'(bram_di), 32'(vecs[i].bdi));
    end

    // Two requesters held for 10 cycles, burst limit 4
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(3'b011, 3'b000, 16'h0100, 16'h0101, 16'h0, 8'h00, 8'h40);
      #1;
      chk($sformatf("burst%0d_gnt", i), 32'(gnt), 32'(burst_exp[i]));
      if (i > 0) chk($sformatf("burst%0d_rvalid", i), 32'(rvalid), 32'(burst_exp[i-1]));
    end
    @(negedge clk);
    drive(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'h41);
    #1;
    chk("burst_tail_rvalid", 32'(rvalid), 32'(burst_exp[9]));
    chk("burst_tail_rdata", 32'(rdata), 32'h41);

    // Sole requester keeps the port past the burst limit
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(3'b010, 3'b000, 16'h0, 16'h0500 + 16'(i), 16'h0, 8'h00, 8'h00);
      #1;
      chk($sformatf("sole%0d_gnt", i), 32'(gnt), 32'h2);
      chk($sformatf("sole%0d_addr", i), 32'(bram_addr), 32'(16'h0500 + 16'(i)));
    end
    @(negedge clk);
    drive(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00);

    // Reset lands on a granted read: the read must be dropped
    @(negedge clk);
    drive(3'b001, 3'b000, 16'h0300, 16'h0, 16'h0, 8'h00, 8'hAA);
    #1;
    chk("rst_pre_gnt", 32'(gnt), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_addr", 32'(bram_addr), 32'h0);
    chk("rst_async_rvalid", 32'(rvalid), 32'h0);
    chk("rst_async_rdata", 32'(rdata), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
    chk("rst_hold_gnt", 32'(gnt), 32'h0);
    chk("rst_hold_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    drive(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'hAA);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_post_rvalid", 32'(rvalid), 32'h0);
    chk("rst_post_rdata", 32'(rdata), 32'h0);

    // First access after reset release
    @(negedge clk);
    drive(3'b001, 3'b000, 16'h0400, 16'h0, 16'h0, 8'h00, 8'h00);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_addr", 32'(bram_addr), 32'h0400);
    @(negedge clk);
    drive(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h00, 8'hBB);
    #1;
    chk("post_rst_rvalid", 32'(rvalid), 32'h1);
    chk("post_rst_rdata", 32'(rdata), 32'hBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
